readcode_burst_responder: RTL and testbench
===========================================

Name: readcode_burst_responder

Overview:
- Memory-side responder for the instruction-fetch readcode interface: one readcode request becomes one Avalon-MM burst read.
- Each returned dword is forwarded as a partial beat. The final beat signals completion and presents the assembled 128-bit line.
- Sits between the icache (initiator) and the memory/Avalon bus, alongside the data-side read path.

Parameters:
LINE_DWORDS, 4, dwords per cache line; only 4 is supported, so bench and RTL assert on any other value.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
readcode_do  in  1  one-cycle request pulse, valid only in IDLE
readcode_address  in  32  request byte address; bits [1:0] ignored
readcode_done  out  1  one-cycle pulse: last beat delivered, readcode_line valid
readcode_line  out  128  assembled line; dword i at bits [32i+31:32i]
readcode_partial  out  32  dword of the current beat
readcode_partial_done  out  1  one-cycle pulse per non-final beat
avm_address  out  30  dword address (byte address [31:2])
avm_read  out  1  read command
avm_burstcount  out  3  beats requested, 1..4
avm_waitrequest  in  1  slave stall
avm_readdata  in  32  returned data
avm_readdatavalid  in  1  data beat valid

Behaviour:
- Reset values (rst high on a clk edge): state IDLE; avm_read=0; avm_address=0; avm_burstcount=0; readcode_done=0; readcode_partial_done=0; readcode_partial=0; readcode_line=0; beat counter=0.
- States: IDLE, CMD, DATA.
- IDLE
  - On readcode_do: latch start dword index s = readcode_address[3:2].
  - Set avm_address = readcode_address[31:2], avm_burstcount = 4 - s (3-bit, range 1..4), avm_read=1.
  - Clear beat counter and go to CMD.
  - avm_read is registered, so the command is first visible 1 cycle after readcode_do.
- CMD
  - Hold avm_read, avm_address and avm_burstcount stable while avm_waitrequest=1.
  - In the cycle avm_waitrequest=0, the command is accepted: next cycle avm_read=0 and state moves to DATA.
  - A readdatavalid beat arriving in the acceptance cycle is counted. The path must tolerate 0-latency slaves.
- Data beats (CMD-accepted cycle or DATA, on avm_readdatavalid)
  - Beat k (0-based) goes to line dword index s+k.
  - Write readcode_line[32(s+k)+:32]; register readcode_partial = avm_readdata.
  - If k < burstcount-1: pulse readcode_partial_done next cycle.
  - If k = burstcount-1: pulse readcode_done next cycle (partial_done stays 0) with readcode_partial = last dword, and return to IDLE.
  - Output latency is therefore 1 cycle from each readdatavalid.
- Line contents:
  - Dwords below s are not written for the current request and hold stale values; the initiator only uses the full line when s=0.
  - readcode_line and readcode_partial hold their values until overwritten.
- readcode_do outside IDLE: ignored, no effect.
  - The cycle readcode_done is asserted the state is already IDLE, so a new readcode_do in that cycle is accepted.
- avm_readdatavalid in IDLE: ignored.
  - No burst is outstanding, so this is a protocol violation; the bench flags it.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. The Avalon slave shares rst, so no orphan beats are expected.
- Counter arithmetic: beat counter is 3 bits and compares against latched burstcount. Index s+k never exceeds 3, so the line index uses 2 bits with no wrap.

Decomposition:
- Shared package/defines: state encodings (IDLE=2'd0, CMD=2'd1, DATA=2'd2) and LINE_DWORDS.
- One natural sub-module: readcode_line_assembler, which holds the 128-bit register and does the indexed dword write (inputs: write enable, 2-bit index, 32-bit data).

Test Plan:
1. Aligned request, zero waitrequest, 1-cycle read latency
   - Stimulus: readcode_do with addr 0x0000_1230; slave returns 0x11111111, 0x22222222, 0x33333333, 0x44444444.
   - Response: avm_address=0x48C, burstcount=4; partial_done pulses 3 times; readcode_done on the 4th beat +1 cycle; line = 0x44444444_33333333_22222222_11111111.
2. Unaligned request
   - Stimulus: readcode_do with addr 0x0000_123A.
   - Response: avm_address=0x48E, burstcount=2; one partial_done then done; dword2/dword3 of the line hold the returned data.
3. waitrequest stall
   - Stimulus: avm_waitrequest=1 for 5 cycles.
   - Response: avm_read/address/burstcount stable all 5 cycles; avm_read drops the cycle after acceptance; data still correct.
4. Gapped beats
   - Stimulus: readdatavalid bursts separated by 3 idle cycles, plus a readcode_do issued in DATA.
   - Response: partial pulses only on beats; the second request is ignored, so no second avm_read.
5. Back-to-back requests
   - Stimulus: readcode_do in the same cycle as readcode_done, addr 0x2000.
   - Response: new command (avm_address=0x800) visible the next cycle.
6. Reset mid-burst
   - Stimulus: rst asserted after beat 1 of 4.
   - Response: next cycle state IDLE, all outputs 0; a subsequent request completes normally.

Source files
------------

// File: rtl/readcode_burst_responder_pkg.sv
// Shared definitions for the readcode burst responder: FSM states and line geometry.
package readcode_burst_responder_pkg;

    localparam int unsigned RC_LINE_DWORDS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

endpackage

// File: rtl/readcode_line_assembler.sv
// 128-bit cache line register with a single indexed dword write port.
module readcode_line_assembler (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_wr_en,
    input  logic [1:0]   i_idx,
    input  logic [31:0]  i_data,
    output logic [127:0] o_line
);

    logic [127:0] r_line;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_line <= '0;
        end else if (i_wr_en) begin
            r_line[{i_idx, 5'd0} +: 32] <= i_data;
        end
    end

    assign o_line = r_line;

endmodule

// File: rtl/readcode_burst_responder.sv
// Turns one icache readcode request into one Avalon-MM burst read and
// forwards each returned dword, assembling the full line on the final beat.
module readcode_burst_responder
    import readcode_burst_responder_pkg::*;
#(
    parameter int unsigned LINE_DWORDS = RC_LINE_DWORDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         readcode_do,
    input  logic [31:0]  readcode_address,
    output logic         readcode_done,
    output logic [127:0] readcode_line,
    output logic [31:0]  readcode_partial,
    output logic         readcode_partial_done,
    output logic [29:0]  avm_address,
    output logic         avm_read,
    output logic [2:0]   avm_burstcount,
    input  logic         avm_waitrequest,
    input  logic [31:0]  avm_readdata,
    input  logic         avm_readdatavalid
);

    if (LINE_DWORDS != 4) begin : g_bad_line_dwords
        $error("readcode_burst_responder: only LINE_DWORDS=4 is supported");
    end

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  r_start;
    logic [2:0]  r_beat;
    logic [2:0]  r_burst;
    logic [29:0] r_avm_address;
    logic        r_avm_read;
    logic [31:0] r_partial;
    logic        r_done;
    logic        r_partial_done;

    logic        w_accept;
    logic        w_beat;
    logic        w_last;
    logic [1:0]  w_line_idx;
    logic [2:0]  w_start_burst;
    logic        w_unused_addr_bits;

    assign w_unused_addr_bits = ^readcode_address[1:0];
    assign w_start_burst      = 3'd4 - {1'b0, readcode_address[3:2]};
    assign w_line_idx         = r_start + r_beat[1:0];

    // A beat in the acceptance cycle counts, so a 0-latency single-beat
    // burst can go straight from CMD back to IDLE.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_beat       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (readcode_do) w_next_state = ST_CMD;
            end
            ST_CMD: begin
                if (!avm_waitrequest) begin
                    w_accept     = 1'b1;
                    w_beat       = avm_readdatavalid;
                    w_next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                w_beat = avm_readdatavalid;
            end
            default: w_next_state = ST_IDLE;
        endcase
        w_last = w_beat && (r_beat == r_burst - 3'd1);
        if (w_last) w_next_state = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_start        <= '0;
            r_beat         <= '0;
            r_burst        <= '0;
            r_avm_address  <= '0;
            r_avm_read     <= 1'b0;
            r_partial      <= '0;
            r_done         <= 1'b0;
            r_partial_done <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_done         <= w_last;
            r_partial_done <= w_beat && !w_last;
            if (w_beat) begin
                r_partial <= avm_readdata;
                r_beat    <= r_beat + 3'd1;
            end
            if (r_state == ST_IDLE && readcode_do) begin
                r_start       <= readcode_address[3:2];
                r_avm_address <= readcode_address[31:2];
                r_burst       <= w_start_burst;
                r_avm_read    <= 1'b1;
                r_beat        <= '0;
            end
            if (w_accept) r_avm_read <= 1'b0;
        end
    end

    readcode_line_assembler u_line (
        .clk     (clk),
        .rst     (rst),
        .i_wr_en (w_beat),
        .i_idx   (w_line_idx),
        .i_data  (avm_readdata),
        .o_line  (readcode_line)
    );

    assign readcode_done         = r_done;
    assign readcode_partial      = r_partial;
    assign readcode_partial_done = r_partial_done;
    assign avm_address           = r_avm_address;
    assign avm_read              = r_avm_read;
    assign avm_burstcount        = r_burst;

endmodule

// File: tb/tb_readcode_burst_responder.sv
// Self-checking bench: directed vector table, hand-written reset sequence and
// randomized requests checked against a beat-level scoreboard model.
module tb_readcode_burst_responder;

    localparam int unsigned LINE_DWORDS = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         readcode_do = 1'b0;
    logic [31:0]  readcode_address = '0;
    logic         readcode_done;
    logic [127:0] readcode_line;
    logic [31:0]  readcode_partial;
    logic         readcode_partial_done;
    logic [29:0]  avm_address;
    logic         avm_read;
    logic [2:0]   avm_burstcount;
    logic         avm_waitrequest = 1'b0;
    logic [31:0]  avm_readdata = '0;
    logic         avm_readdatavalid = 1'b0;

    readcode_burst_responder #(.LINE_DWORDS(LINE_DWORDS)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .readcode_do           (readcode_do),
        .readcode_address      (readcode_address),
        .readcode_done         (readcode_done),
        .readcode_line         (readcode_line),
        .readcode_partial      (readcode_partial),
        .readcode_partial_done (readcode_partial_done),
        .avm_address           (avm_address),
        .avm_read              (avm_read),
        .avm_burstcount        (avm_burstcount),
        .avm_waitrequest       (avm_waitrequest),
        .avm_readdata          (avm_readdata),
        .avm_readdatavalid     (avm_readdatavalid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;
    bit burst_active = 1'b0;

    typedef struct {
        int          due;
        bit          last;
        logic [31:0] data;
    } beat_t;
    beat_t expq[$];
    logic [31:0] model_line [4];

    typedef struct {
        logic [31:0]  addr;
        int unsigned  nwait;
        int unsigned  lat;
        int unsigned  gap;
        bit           stray;
        bit           fixed;
        bit           b2b;
        logic [29:0]  exp_addr;
        logic [2:0]   exp_burst;
        bit           chk_line;
        logic [127:0] exp_line;
    } vec_t;
    vec_t vecs [6];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output scoreboard: each driven beat must surface exactly one cycle later.
    beat_t  m_e;
    bit     m_exp_p, m_exp_d;
    always @(negedge clk) begin
        if (mon_en) begin
            m_exp_p = 1'b0;
            m_exp_d = 1'b0;
            if (expq.size() > 0 && expq[0].due <= cyc) begin
                m_e = expq.pop_front();
                if (m_e.due == cyc) begin
                    m_exp_p = !m_e.last;
                    m_exp_d = m_e.last;
                end
            end
            check("partial_done", readcode_partial_done, m_exp_p);
            check("done", readcode_done, m_exp_d);
            if (m_exp_p || m_exp_d) check("partial_data", readcode_partial, m_e.data);
            if (m_exp_d)
                check("line_model", readcode_line,
                      {model_line[3], model_line[2], model_line[1], model_line[0]});
            if (avm_readdatavalid) check("rdv_outside_burst", burst_active, 1'b1);
        end
    end

    task automatic run_req(input logic [31:0] addr, input int unsigned nwait,
                           input int unsigned lat, input int unsigned gap,
                           input bit stray, input bit fixed,
                           input logic [29:0] exp_addr, input logic [2:0] exp_burst);
        int          s;
        int          n;
        bit          acc_checked;
        logic [31:0] d;
        s = int'(addr[3:2]);
        n = 4 - s;
        acc_checked = 1'b0;
        readcode_address = addr;
        readcode_do = 1'b1;
        tick();
        readcode_do = 1'b0;
        readcode_address = $urandom;
        check("cmd_read", avm_read, 1'b1);
        check("cmd_address", avm_address, exp_addr);
        check("cmd_burst", avm_burstcount, exp_burst);
        for (int j = 0; j < int'(nwait); j++) begin
            avm_waitrequest = 1'b1;
            tick();
            check("stall_read", avm_read, 1'b1);
            check("stall_address", avm_address, exp_addr);
            check("stall_burst", avm_burstcount, exp_burst);
        end
        avm_waitrequest = 1'b0;
        burst_active = 1'b1;
        for (int k = 0; k < n; k++) begin
            int unsigned idle;
            idle = (k == 0) ? lat : gap;
            for (int j = 0; j < int'(idle); j++) begin
                if (stray && k == 1 && j == 0) begin
                    readcode_do = 1'b1;
                    readcode_address = 32'h0000_4000;
                end
                tick();
                readcode_do = 1'b0;
                if (!acc_checked) begin
                    check("read_drop", avm_read, 1'b0);
                    acc_checked = 1'b1;
                end
            end
            d = fixed ? 32'h1111_1111 * (k + 1) : $urandom;
            avm_readdatavalid = 1'b1;
            avm_readdata = d;
            model_line[s + k] = d;
            expq.push_back('{due: cyc + 1, last: (k == n - 1), data: d});
            tick();
            avm_readdatavalid = 1'b0;
            avm_readdata = $urandom;
            if (!acc_checked) begin
                check("read_drop", avm_read, 1'b0);
                acc_checked = 1'b1;
            end
        end
        burst_active = 1'b0;
    endtask

    initial begin : wd
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;

        if (LINE_DWORDS != 4) begin
            $display("FAIL line_dwords: got %0d expected 4", LINE_DWORDS);
            $fatal(1, "unsupported LINE_DWORDS");
        end

        vecs[0] = '{32'h0000_1230, 0, 1, 0, 1'b0, 1'b1, 1'b0, 30'h48C, 3'd4, 1'b1,
                    128'h44444444_33333333_22222222_11111111};
        vecs[1] = '{32'h0000_123A, 0, 1, 0, 1'b0, 1'b1, 1'b0, 30'h48E, 3'd2, 1'b1,
                    128'h22222222_11111111_22222222_11111111};
        vecs[2] = '{32'h0000_6000, 0, 1, 3, 1'b1, 1'b0, 1'b0, 30'h1800, 3'd4, 1'b0, '0};
        vecs[3] = '{32'h0000_5004, 5, 2, 0, 1'b0, 1'b0, 1'b0, 30'h1401, 3'd3, 1'b0, '0};
        vecs[4] = '{32'h0000_2000, 0, 0, 1, 1'b0, 1'b0, 1'b1, 30'h800, 3'd4, 1'b0, '0};
        vecs[5] = '{32'h0000_000C, 0, 0, 0, 1'b0, 1'b0, 1'b1, 30'h3, 3'd1, 1'b0, '0};

        for (int i = 0; i < 4; i++) model_line[i] = '0;

        rst = 1'b1;
        tick();
        tick();
        check("rst_read", avm_read, 1'b0);
        check("rst_address", avm_address, 30'd0);
        check("rst_burst", avm_burstcount, 3'd0);
        check("rst_done", readcode_done, 1'b0);
        check("rst_partial_done", readcode_partial_done, 1'b0);
        check("rst_partial", readcode_partial, 32'd0);
        check("rst_line", readcode_line, 128'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            if (!vecs[i].b2b) tick();
            run_req(vecs[i].addr, vecs[i].nwait, vecs[i].lat, vecs[i].gap,
                    vecs[i].stray, vecs[i].fixed, vecs[i].exp_addr, vecs[i].exp_burst);
            if (vecs[i].chk_line) check($sformatf("vec%0d_line", i), readcode_line, vecs[i].exp_line);
            if (vecs[i].stray) begin
                check("stray_no_cmd", avm_read, 1'b0);
                tick();
                check("stray_no_cmd_next", avm_read, 1'b0);
            end
        end

        // Reset after the first beat of a 4-beat burst.
        tick();
        readcode_address = 32'h0000_3000;
        readcode_do = 1'b1;
        tick();
        readcode_do = 1'b0;
        check("mid_cmd_read", avm_read, 1'b1);
        avm_waitrequest = 1'b0;
        burst_active = 1'b1;
        d = 32'hCAFE_0001;
        avm_readdatavalid = 1'b1;
        avm_readdata = d;
        model_line[0] = d;
        expq.push_back('{due: cyc + 1, last: 1'b0, data: d});
        tick();
        avm_readdatavalid = 1'b0;
        burst_active = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) model_line[i] = '0;
        check("mid_rst_read", avm_read, 1'b0);
        check("mid_rst_address", avm_address, 30'd0);
        check("mid_rst_burst", avm_burstcount, 3'd0);
        check("mid_rst_partial", readcode_partial, 32'd0);
        check("mid_rst_line", readcode_line, 128'd0);
        tick();
        run_req(32'h0000_7010, 1, 1, 0, 1'b0, 1'b1, 30'h1C04, 3'd4);
        check("post_rst_line", readcode_line, 128'h44444444_33333333_22222222_11111111);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 1) tick();
            run_req(a, $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2),
                    1'b0, 1'b0, a[31:2], 3'(4 - int'(a[3:2])));
        end

        tick();
        tick();
        check("scoreboard_drained", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
